// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, datapath widths and GF(2^8) helpers.
// Used by inv_mix_columns_seq and inv_mix_column (optional FWD_MIX_EN build adds forward mixing).
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;
    localparam int AES_NCOL    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; covers every MixColumns/InvMixColumns coefficient.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational mixing of one 32-bit AES column (row 0 in the MSB byte).
// Inverse coefficients by default; FWD_MIX_EN adds a forward-mode select.
module inv_mix_column
    import aes_pkg::*;
(
`ifdef FWD_MIX_EN
    input  logic                 i_fwd_mode,
`endif
    input  logic [AES_COL_W-1:0] i_col,
    output logic [AES_COL_W-1:0] o_col
);

    logic [7:0] w_a     [AES_NCOL];
    logic [7:0] w_b_inv [AES_NCOL];
    logic [7:0] w_b_fwd [AES_NCOL];

    genvar gi;
    generate
        for (gi = 0; gi < AES_NCOL; gi++) begin : g_row
            assign w_a[gi] = i_col[AES_COL_W-1-8*gi -: 8];

            // Each output row uses the coefficient row rotated right by its index.
            assign w_b_inv[gi] = gf_mul_const(w_a[gi],                4'd14)
                               ^ gf_mul_const(w_a[(gi+1)%AES_NCOL],   4'd11)
                               ^ gf_mul_const(w_a[(gi+2)%AES_NCOL],   4'd13)
                               ^ gf_mul_const(w_a[(gi+3)%AES_NCOL],   4'd9);

            assign w_b_fwd[gi] = gf_mul_const(w_a[gi],                4'd2)
                               ^ gf_mul_const(w_a[(gi+1)%AES_NCOL],   4'd3)
                               ^ w_a[(gi+2)%AES_NCOL]
                               ^ w_a[(gi+3)%AES_NCOL];

`ifdef FWD_MIX_EN
            assign o_col[AES_COL_W-1-8*gi -: 8] = i_fwd_mode ? w_b_fwd[gi] : w_b_inv[gi];
`else
            assign o_col[AES_COL_W-1-8*gi -: 8] = w_b_inv[gi];
            wire w_unused_fwd = ^w_b_fwd[gi];
`endif
        end
    endgenerate

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: one column per clock, valid/ready on both sides, 4-clock latency.
// Define FWD_MIX_EN to add the fwd_mode input selecting forward MixColumns per state.
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef FWD_MIX_EN
    input  logic                   fwd_mode,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    aes_state_e             r_state;
    logic [1:0]             r_col_cnt;
    logic [AES_STATE_W-1:0] r_work;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [6:0]             w_lsb;
    logic [AES_COL_W-1:0]   w_col_in;
    logic [AES_COL_W-1:0]   w_col_out;

    // Column c sits at bit offset 32*(3-c), i.e. the inverted count shifted by 5.
    assign w_lsb    = {~r_col_cnt, 5'b00000};
    assign w_col_in = r_work[w_lsb +: AES_COL_W];

`ifdef FWD_MIX_EN
    logic r_mode;

    inv_mix_column u_mix (
        .i_fwd_mode (r_mode),
        .i_col      (w_col_in),
        .o_col      (w_col_out)
    );
`else
    inv_mix_column u_mix (
        .i_col      (w_col_in),
        .o_col      (w_col_out)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_col_cnt   <= 2'd0;
            r_work      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef FWD_MIX_EN
            r_mode      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work     <= in_state;
                        r_col_cnt  <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
`ifdef FWD_MIX_EN
                        r_mode     <= fwd_mode;
`endif
                    end
                end
                BUSY: begin
                    r_work[w_lsb +: AES_COL_W] <= w_col_out;
                    r_col_cnt                  <= r_col_cnt + 2'd1;
                    if (r_col_cnt == 2'd3) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_work;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: directed vectors, stalls, back-to-back, reset.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
`ifdef FWD_MIX_EN
    logic         fwd_mode;
`endif

    int errors = 0;
    int checks = 0;

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef FWD_MIX_EN
        .fwd_mode  (fwd_mode),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry-less 8x8 product followed by reduction modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input bit fwd);
        logic [7:0]   inv_row [4];
        logic [7:0]   fwd_row [4];
        logic [7:0]   coef;
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r;
        inv_row = '{8'd14, 8'd11, 8'd13, 8'd9};
        fwd_row = '{8'd2, 8'd3, 8'd1, 8'd1};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    coef = fwd ? fwd_row[(k - row + 4) % 4] : inv_row[(k - row + 4) % 4];
                    b = b ^ gmul(coef, a[k]);
                end
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_state(input string tag, input logic [127:0] s, input bit fwd,
                             input logic [127:0] exp);
        int n;
        int lat;
        in_state = s;
        in_valid = 1'b1;
`ifdef FWD_MIX_EN
        fwd_mode = fwd;
`endif
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        chk({tag, "_latency"}, 128'(lat), 128'd4);
        chk(tag, out_state, exp);
        $display("txn %s in=%h out=%h latency=%0d", tag, s, out_state, lat);
        drain();
    endtask

    logic [127:0] st_a;
    logic [127:0] st_b;
    logic [127:0] exp_a;
    logic [127:0] cur;
    logic [127:0] exp_q [$];
    logic [127:0] front;
    int lat;
    int sent;
    int got;
    int cyc;
    int last;
    bit acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        out_ready = 1'b0;
`ifdef FWD_MIX_EN
        fwd_mode  = 1'b0;
`endif
        repeat (3) tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_state", out_state, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_state("known_col0", {32'h8e4da1bc, 96'h0}, 1'b0, {32'hdb135345, 96'h0});
        run_state("ones", {4{32'h01010101}}, 1'b0, {4{32'h01010101}});
        run_state("c6", {4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}});
        run_state("d5_col0", {32'hd5d5d7d6, 96'h0}, 1'b0, {32'hd4d4d4d5, 96'h0});
        for (int i = 0; i < 4; i++) begin
            st_a = {$urandom, $urandom, $urandom, $urandom};
            run_state($sformatf("rand%0d", i), st_a, 1'b0, model(st_a, 1'b0));
        end

        // Stall in DONE while a second state waits on in_valid.
        st_a = {$urandom, $urandom, $urandom, $urandom};
        st_b = {$urandom, $urandom, $urandom, $urandom};
        exp_a = model(st_a, 1'b0);
        in_state = st_a;
        in_valid = 1'b1;
        tick();
        in_state = st_b;
        wait_out(lat);
        chk("stall_latency", 128'(lat), 128'd4);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_out_valid", 128'(out_valid), 128'd1);
            chk("stall_out_state", out_state, exp_a);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        $display("txn stall in=%h out=%h held 10 cycles", st_a, out_state);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_valid", 128'(out_valid), 128'd0);
        chk("stall_release_ready", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("second_accept_ready", 128'(in_ready), 128'd0);
        wait_out(lat);
        chk("second_latency", 128'(lat), 128'd4);
        chk("second_state", out_state, model(st_b, 1'b0));
        $display("txn second in=%h out=%h", st_b, out_state);
        drain();

        // Back-to-back with both handshakes permanently asserted.
        out_ready = 1'b1;
        cur = {$urandom, $urandom, $urandom, $urandom};
        in_state = cur;
        in_valid = 1'b1;
        sent = 0; got = 0; cyc = 0; last = -1;
        while (got < 6 && cyc < 300) begin
            acc = in_ready && in_valid;
            if (acc) exp_q.push_back(model(cur, 1'b0));
            if (out_valid) begin
                front = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                chk("b2b_state", out_state, front);
                if (last >= 0)
                    chk("b2b_interval", 128'((cyc - last) >= 5 && (cyc - last) <= 6), 128'd1);
                $display("txn b2b%0d out=%h cycle=%0d", got, out_state, cyc);
                last = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                sent++;
                cur = {$urandom, $urandom, $urandom, $urandom};
                in_state = cur;
            end
            in_valid = (sent < 6);
        end
        chk("b2b_count", 128'(got), 128'd6);
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (8) tick();

        // Asynchronous reset while BUSY at col_cnt 2.
        st_a = {$urandom, $urandom, $urandom, $urandom};
        in_state = st_a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
        chk("rst_mid_out_state", out_state, 128'd0);
        chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
        $display("txn reset_mid_busy out_valid=%b in_ready=%b", out_valid, in_ready);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        st_b = {$urandom, $urandom, $urandom, $urandom};
        run_state("after_reset", st_b, 1'b0, model(st_b, 1'b0));

`ifdef FWD_MIX_EN
        run_state("fwd_known", {32'hdb135345, 96'h0}, 1'b1, {32'h8e4da1bc, 96'h0});
        st_a = {$urandom, $urandom, $urandom, $urandom};
        run_state("fwd_rand", st_a, 1'b1, model(st_a, 1'b1));
        run_state("inv_after_fwd", st_a, 1'b0, model(st_a, 1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
